dds_sweep_ctrl: RTL and testbench
=================================

DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 Parameter FW_W, default 28, frequency control word width.
REQ-002 Parameter PW_W, default 12, phase control word width.
REQ-003 Parameter DW_W, default 16, dwell counter width.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to begin a sweep; honored only in IDLE.
REQ-007 abort  in  1  terminate any sweep in progress.
REQ-008 f_start  in  FW_W  first frequency word.
REQ-009 f_stop  in  FW_W  final frequency word.
REQ-010 f_step  in  FW_W  frequency increment magnitude.
REQ-011 dwell  in  DW_W  cycles each frequency is held; 0 is treated as 1.
REQ-012 pword_in  in  PW_W  phase word applied for the sweep.
REQ-013 fword  out  FW_W  frequency word to the DDS.
REQ-014 pword  out  PW_W  phase word to the DDS.
REQ-015 fword_vld  out  1  one-cycle pulse whenever fword takes a new sweep value.
REQ-016 busy  out  1  high while a sweep is active.
REQ-017 done  out  1  one-cycle pulse on normal sweep completion.

Function
REQ-018 FSM states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE after the last point's dwell expires; DONE->IDLE unconditionally the next cycle.
REQ-019 On start, f_start, f_stop, f_step, dwell, pword_in are latched; later input changes do not affect the active sweep.
REQ-020 Cycle after start is sampled: fword=f_start, pword=pword_in, fword_vld=1, busy=1.
REQ-021 Each point is held exactly max(dwell,1) cycles; the next point's fword_vld occurs max(dwell,1) cycles after the previous one.
REQ-022 Direction: up if f_stop >= f_start, else down; next = current +/- f_step computed at FW_W+1 bits.
REQ-023 If next passes f_stop (or wraps beyond 0 / 2^FW_W-1), fword is clamped to f_stop, and that point is the last.
REQ-024 f_step = 0 or f_start = f_stop: single point f_start, one dwell, then done.
REQ-025 done pulses in the DONE cycle; busy deasserts in that same cycle.
REQ-026 start while busy is ignored; start in the DONE cycle is ignored.
REQ-027 abort in RUN: next cycle state=IDLE, busy=0, done=0, fword/pword hold last value, no fword_vld.
REQ-028 abort and start asserted together in IDLE: abort wins, no sweep starts.
REQ-029 fword and pword hold their last values in IDLE.

Reset
REQ-030 rst asserted: immediately state=IDLE, fword=0, pword=0, fword_vld=0, busy=0, done=0, dwell counter=0, regardless of state.
REQ-031 After rst deasserts, the first start is honored on the first rising edge at which it is sampled.

Configuration
REQ-032 Macro SWEEP_LOOP_EN defined: on reaching the last point's dwell expiry, the sweep restarts at the latched f_start (with fword_vld) and repeats until abort; done never pulses.
REQ-033 Macro SWEEP_LOOP_EN undefined: behaviour per REQ-018..REQ-025, single pass.

Structure
REQ-034 Shared package dds_pkg holds FW_W/PW_W/DW_W defaults and the FSM state enum.
REQ-035 Dwell counting is implemented in one sub-module dds_dwell_timer (load, count-down, expire pulse).

Verification
REQ-036 f_start=1000, f_stop=1300, f_step=100, dwell=4, start@cycle 0 -> fword 1000/1100/1200/1300 with vld at cycles 1/5/9/13, done at 17.
REQ-037 f_start=1000, f_stop=1250, f_step=100, dwell=2 -> fword 1000,1100,1200,1250, then done.
REQ-038 f_start=1300, f_stop=1000, f_step=100, dwell=1 -> fword 1300,1200,1100,1000 on consecutive cycles, then done.
REQ-039 f_start=28'hFFFFF00, f_stop=28'hFFFFFFF, f_step=28'h80 -> fword FFFFF00, FFFFF80, FFFFFFF, no wrap.
REQ-040 Abort at 2nd point, then rst mid-sweep in a new run -> busy=0, no done, fword held after abort, all outputs 0 after rst.
REQ-041 With SWEEP_LOOP_EN, 1000->1200 step 100 -> 1000,1100,1200,1000,... with no done until abort.

Source files
------------

// File: rtl/dds_pkg.sv
// dds_pkg -- shared definitions for the DDS frequency sweep controller.
//   FW_W_DEFAULT : default frequency control word width
//   PW_W_DEFAULT : default phase control word width
//   DW_W_DEFAULT : default dwell counter width
//   state_e      : sweep controller FSM states (IDLE, RUN, DONE)
package dds_pkg;

  localparam int FW_W_DEFAULT = 28;
  localparam int PW_W_DEFAULT = 12;
  localparam int DW_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/dds_dwell_timer.sv
// dds_dwell_timer -- per-point dwell counter for the sweep controller.
// Ports:
//   clk, rst  : clock and asynchronous active-high reset
//   load      : reload the counter for a new point (takes priority)
//   load_val  : dwell length in cycles, must be >= 1
//   en        : counter runs only while enabled (sweep active)
//   expire    : high during the final cycle of the current dwell
module dds_dwell_timer
  import dds_pkg::*;
#(
  parameter int DW_W = DW_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [DW_W-1:0] load_val,
  input  logic            en,
  output logic            expire
);

  logic [DW_W-1:0] cnt_q;
  logic [DW_W-1:0] cnt_d;

  // Counter holds "cycles left after this one", so a dwell of N loads N-1
  // and expire fires on the Nth cycle of the point.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val - 1'b1;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign expire = en && (cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl -- steps a DDS frequency word from f_start towards f_stop in
// f_step increments, holding each point for max(dwell,1) cycles.
// Ports:
//   clk, rst            : clock and asynchronous active-high reset
//   start, abort        : sweep request (IDLE only) and sweep termination
//   f_start/f_stop/f_step, dwell, pword_in : sweep setup, latched on start
//   fword, pword        : words driven to the DDS, held while idle
//   fword_vld           : one-cycle pulse per new sweep point
//   busy, done          : sweep active, and single-cycle completion pulse
// Build option: define SWEEP_LOOP_EN to restart at f_start after the last
// point forever (until abort); done then never pulses.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int FW_W = FW_W_DEFAULT,
  parameter int PW_W = PW_W_DEFAULT,
  parameter int DW_W = DW_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [FW_W-1:0] f_start,
  input  logic [FW_W-1:0] f_stop,
  input  logic [FW_W-1:0] f_step,
  input  logic [DW_W-1:0] dwell,
  input  logic [PW_W-1:0] pword_in,
  output logic [FW_W-1:0] fword,
  output logic [PW_W-1:0] pword,
  output logic            fword_vld,
  output logic            busy,
  output logic            done
);

  state_e          state_q, state_d;
  logic [FW_W-1:0] fword_q, fword_d;
  logic [PW_W-1:0] pword_q, pword_d;
  logic            vld_q, vld_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [FW_W-1:0] f_stop_q, f_stop_d;
  logic [FW_W-1:0] f_step_q, f_step_d;
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic            up_q, up_d;
  logic            last_q, last_d;
`ifdef SWEEP_LOOP_EN
  logic [FW_W-1:0] f_start_q, f_start_d;
`endif

  logic            tmr_load;
  logic [DW_W-1:0] tmr_val;
  logic            tmr_expire;
  logic [DW_W-1:0] dwell_in_eff;
  logic [FW_W:0]   sum_ext;
  logic [FW_W:0]   diff_ext;
  logic            clamp;
  logic [FW_W-1:0] next_f;

  dds_dwell_timer #(.DW_W(DW_W)) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (state_q == ST_RUN),
    .expire   (tmr_expire)
  );

  // Next-point arithmetic is one bit wider so a carry or borrow out of the
  // word counts as overshooting f_stop rather than wrapping around.
  always_comb begin
    dwell_in_eff = (dwell == '0) ? DW_W'(1) : dwell;
    sum_ext      = {1'b0, fword_q} + {1'b0, f_step_q};
    diff_ext     = {1'b0, fword_q} - {1'b0, f_step_q};
    if (up_q) begin
      clamp  = (sum_ext >= {1'b0, f_stop_q});
      next_f = sum_ext[FW_W-1:0];
    end else begin
      clamp  = diff_ext[FW_W] || (diff_ext[FW_W-1:0] <= f_stop_q);
      next_f = diff_ext[FW_W-1:0];
    end
    if (clamp) begin
      next_f = f_stop_q;
    end
  end

  // Sweep FSM: every new point reloads the dwell timer and pulses fword_vld;
  // abort has priority over everything in RUN and over start in IDLE.
  always_comb begin
    state_d  = state_q;
    fword_d  = fword_q;
    pword_d  = pword_q;
    vld_d    = 1'b0;
    f_stop_d = f_stop_q;
    f_step_d = f_step_q;
    dwell_d  = dwell_q;
    up_d     = up_q;
    last_d   = last_q;
    tmr_load = 1'b0;
    tmr_val  = dwell_q;
`ifdef SWEEP_LOOP_EN
    f_start_d = f_start_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d  = ST_RUN;
          fword_d  = f_start;
          pword_d  = pword_in;
          vld_d    = 1'b1;
          f_stop_d = f_stop;
          f_step_d = f_step;
          dwell_d  = dwell_in_eff;
          up_d     = (f_stop >= f_start);
          last_d   = (f_step == '0) || (f_start == f_stop);
          tmr_load = 1'b1;
          tmr_val  = dwell_in_eff;
`ifdef SWEEP_LOOP_EN
          f_start_d = f_start;
`endif
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (tmr_expire) begin
          if (last_q) begin
`ifdef SWEEP_LOOP_EN
            fword_d  = f_start_q;
            vld_d    = 1'b1;
            tmr_load = 1'b1;
            last_d   = (f_step_q == '0) || (f_start_q == f_stop_q);
`else
            state_d = ST_DONE;
`endif
          end else begin
            fword_d  = next_f;
            vld_d    = 1'b1;
            tmr_load = 1'b1;
            last_d   = clamp;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      fword_q  <= '0;
      pword_q  <= '0;
      vld_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      f_stop_q <= '0;
      f_step_q <= '0;
      dwell_q  <= '0;
      up_q     <= 1'b0;
      last_q   <= 1'b0;
`ifdef SWEEP_LOOP_EN
      f_start_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      fword_q  <= fword_d;
      pword_q  <= pword_d;
      vld_q    <= vld_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      f_stop_q <= f_stop_d;
      f_step_q <= f_step_d;
      dwell_q  <= dwell_d;
      up_q     <= up_d;
      last_q   <= last_d;
`ifdef SWEEP_LOOP_EN
      f_start_q <= f_start_d;
`endif
    end
  end

  assign fword     = fword_q;
  assign pword     = pword_q;
  assign fword_vld = vld_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb_dds_sweep_ctrl -- directed self-checking bench for dds_sweep_ctrl.
// Cycle numbering: the cycle in which start is driven is cycle 0; outputs are
// sampled 1 time unit after each rising edge.
module tb_dds_sweep_ctrl;

  localparam int FW_W = 28;
  localparam int PW_W = 12;
  localparam int DW_W = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            abort;
  logic [FW_W-1:0] f_start;
  logic [FW_W-1:0] f_stop;
  logic [FW_W-1:0] f_step;
  logic [DW_W-1:0] dwell;
  logic [PW_W-1:0] pword_in;
  logic [FW_W-1:0] fword;
  logic [PW_W-1:0] pword;
  logic            fword_vld;
  logic            busy;
  logic            done;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [FW_W-1:0] obs_f [16];
  int              obs_c [16];
  int              obs_n;
  int              done_c;
  logic            busy_at_done;

  dds_sweep_ctrl #(.FW_W(FW_W), .PW_W(PW_W), .DW_W(DW_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .f_start   (f_start),
    .f_stop    (f_stop),
    .f_step    (f_step),
    .dwell     (dwell),
    .pword_in  (pword_in),
    .fword     (fword),
    .pword     (pword),
    .fword_vld (fword_vld),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a start pulse in the current cycle; returns in cycle 1.
  task automatic launch(input logic [FW_W-1:0] fs, input logic [FW_W-1:0] fe,
                        input logic [FW_W-1:0] st, input logic [DW_W-1:0] dw,
                        input logic [PW_W-1:0] pw);
    f_start  = fs;
    f_stop   = fe;
    f_step   = st;
    dwell    = dw;
    pword_in = pw;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  // Record every fword_vld point and the done cycle; inputs are scrambled so
  // that a design that fails to latch them shows up as wrong points.
  task automatic collect(input int budget);
    obs_n        = 0;
    done_c       = -1;
    busy_at_done = 1'bx;
    for (int i = 0; i < 16; i++) begin
      obs_f[i] = '0;
      obs_c[i] = -1;
    end
    f_start  = 28'h0ABCDEF;
    f_stop   = 28'h0000010;
    f_step   = 28'h0000007;
    dwell    = 16'd9;
    pword_in = 12'hFFF;
    for (int c = 1; c <= budget; c++) begin
      if (fword_vld) begin
        if (obs_n < 16) begin
          obs_f[obs_n] = fword;
          obs_c[obs_n] = c;
        end
        obs_n++;
      end
      if (done) begin
        done_c       = c;
        busy_at_done = busy;
        break;
      end
      step();
    end
    if (done_c < 0) begin
      rst = 1'b1;
      #2;
      rst = 1'b0;
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    f_start = '0; f_stop = '0; f_step = '0; dwell = '0; pword_in = '0;
    step();
    step();
    tests_run++;
    if (fword !== '0) begin tests_failed++; $display("[TB] FAIL reset fword: got %0h, expected 0", fword); end
    tests_run++;
    if (pword !== '0) begin tests_failed++; $display("[TB] FAIL reset pword: got %0h, expected 0", pword); end
    tests_run++;
    if (fword_vld !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset fword_vld: got %b, expected 0", fword_vld); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset busy: got %b, expected 0", busy); end
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset done: got %b, expected 0", done); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic_up();
    logic [FW_W-1:0] ef [4] = '{28'd1000, 28'd1100, 28'd1200, 28'd1300};
    int              ec [4] = '{1, 5, 9, 13};
    launch(28'd1000, 28'd1300, 28'd100, 16'd4, 12'h3A5);
    tests_run++;
    if (busy !== 1'b1 || pword !== 12'h3A5) begin
      tests_failed++;
      $display("[TB] FAIL basic first cycle: got busy=%b pword=%h, expected busy=1 pword=3a5", busy, pword);
    end
    collect(60);
    tests_run++;
    if (obs_n !== 4) begin tests_failed++; $display("[TB] FAIL basic point count: got %0d, expected 4", obs_n); end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (obs_f[i] !== ef[i] || obs_c[i] !== ec[i]) begin
        tests_failed++;
        $display("[TB] FAIL basic point %0d: got %0d at cycle %0d, expected %0d at cycle %0d", i, obs_f[i], obs_c[i], ef[i], ec[i]);
      end
    end
    tests_run++;
    if (done_c !== 17 || busy_at_done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL basic done: got cycle %0d busy=%b, expected cycle 17 busy=0", done_c, busy_at_done);
    end
    tests_run++;
    if (pword !== 12'h3A5 || fword !== 28'd1300) begin
      tests_failed++;
      $display("[TB] FAIL basic idle hold: got fword=%0d pword=%h, expected 1300 3a5", fword, pword);
    end
  endtask

  task automatic test_clamp();
    logic [FW_W-1:0] ef [4] = '{28'd1000, 28'd1100, 28'd1200, 28'd1250};
    int              ec [4] = '{1, 3, 5, 7};
    launch(28'd1000, 28'd1250, 28'd100, 16'd2, 12'h001);
    collect(60);
    tests_run++;
    if (obs_n !== 4) begin tests_failed++; $display("[TB] FAIL clamp point count: got %0d, expected 4", obs_n); end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (obs_f[i] !== ef[i] || obs_c[i] !== ec[i]) begin
        tests_failed++;
        $display("[TB] FAIL clamp point %0d: got %0d at cycle %0d, expected %0d at cycle %0d", i, obs_f[i], obs_c[i], ef[i], ec[i]);
      end
    end
    tests_run++;
    if (done_c !== 9) begin tests_failed++; $display("[TB] FAIL clamp done: got cycle %0d, expected 9", done_c); end
  endtask

  task automatic test_down();
    logic [FW_W-1:0] ef [4] = '{28'd1300, 28'd1200, 28'd1100, 28'd1000};
    int              ec [4] = '{1, 2, 3, 4};
    launch(28'd1300, 28'd1000, 28'd100, 16'd1, 12'h002);
    collect(60);
    tests_run++;
    if (obs_n !== 4) begin tests_failed++; $display("[TB] FAIL down point count: got %0d, expected 4", obs_n); end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (obs_f[i] !== ef[i] || obs_c[i] !== ec[i]) begin
        tests_failed++;
        $display("[TB] FAIL down point %0d: got %0d at cycle %0d, expected %0d at cycle %0d", i, obs_f[i], obs_c[i], ef[i], ec[i]);
      end
    end
    tests_run++;
    if (done_c !== 5) begin tests_failed++; $display("[TB] FAIL down done: got cycle %0d, expected 5", done_c); end
  endtask

  // Top-of-range sweep with dwell=0, which must behave as dwell=1.
  task automatic test_no_wrap();
    logic [FW_W-1:0] ef [3] = '{28'hFFFFF00, 28'hFFFFF80, 28'hFFFFFFF};
    int              ec [3] = '{1, 2, 3};
    launch(28'hFFFFF00, 28'hFFFFFFF, 28'h80, 16'd0, 12'h003);
    collect(60);
    tests_run++;
    if (obs_n !== 3) begin tests_failed++; $display("[TB] FAIL wrap point count: got %0d, expected 3", obs_n); end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (obs_f[i] !== ef[i] || obs_c[i] !== ec[i]) begin
        tests_failed++;
        $display("[TB] FAIL wrap point %0d: got %h at cycle %0d, expected %h at cycle %0d", i, obs_f[i], obs_c[i], ef[i], ec[i]);
      end
    end
    tests_run++;
    if (done_c !== 4) begin tests_failed++; $display("[TB] FAIL wrap done: got cycle %0d, expected 4", done_c); end
  endtask

  task automatic test_single_point();
    launch(28'd500, 28'd900, 28'd0, 16'd3, 12'h004);
    collect(60);
    tests_run++;
    if (obs_n !== 1 || obs_f[0] !== 28'd500 || obs_c[0] !== 1) begin
      tests_failed++;
      $display("[TB] FAIL single point: got n=%0d f=%0d c=%0d, expected n=1 f=500 c=1", obs_n, obs_f[0], obs_c[0]);
    end
    tests_run++;
    if (done_c !== 4) begin tests_failed++; $display("[TB] FAIL single done: got cycle %0d, expected 4", done_c); end
  endtask

  task automatic test_ignored_start();
    int bad;
    launch(28'd1000, 28'd1300, 28'd100, 16'd4, 12'h011);
    step();
    start = 1'b1; f_start = 28'd5; f_stop = 28'd7; f_step = 28'd1; dwell = 16'd1;
    step();
    start = 1'b0;
    step();
    step();
    tests_run++;
    if (fword_vld !== 1'b1 || fword !== 28'd1100) begin
      tests_failed++;
      $display("[TB] FAIL start while busy: got vld=%b fword=%0d, expected vld=1 fword=1100", fword_vld, fword);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
    start = 1'b1; abort = 1'b1; f_start = 28'd777; f_stop = 28'd800; f_step = 28'd1;
    step();
    start = 1'b0; abort = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || fword_vld !== 1'b0 || fword !== 28'd1100) begin
      tests_failed++;
      $display("[TB] FAIL abort with start: got busy=%b vld=%b fword=%0d, expected 0 0 1100", busy, fword_vld, fword);
    end
    step();
    launch(28'd50, 28'd50, 28'd0, 16'd1, 12'h012);
    step();
    tests_run++;
    if (done !== 1'b1) begin tests_failed++; $display("[TB] FAIL single dwell1 done: got %b, expected 1", done); end
    start = 1'b1; f_start = 28'd900; f_stop = 28'd950; f_step = 28'd10;
    step();
    start = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (busy !== 1'b0 || fword_vld !== 1'b0 || fword !== 28'd50) bad++;
      step();
    end
    tests_run++;
    if (bad !== 0) begin tests_failed++; $display("[TB] FAIL start in done: got %0d bad idle cycles, expected 0", bad); end
  endtask

  task automatic test_abort_reset();
    int bad;
    launch(28'd1000, 28'd1300, 28'd100, 16'd4, 12'h155);
    for (int i = 0; i < 4; i++) step();
    tests_run++;
    if (fword_vld !== 1'b1 || fword !== 28'd1100) begin
      tests_failed++;
      $display("[TB] FAIL abort setup: got vld=%b fword=%0d, expected vld=1 fword=1100", fword_vld, fword);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || fword_vld !== 1'b0 || fword !== 28'd1100 || pword !== 12'h155) begin
      tests_failed++;
      $display("[TB] FAIL abort: got busy=%b done=%b vld=%b fword=%0d pword=%h, expected 0 0 0 1100 155",
               busy, done, fword_vld, fword, pword);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (done !== 1'b0 || fword_vld !== 1'b0 || busy !== 1'b0 || fword !== 28'd1100) bad++;
      step();
    end
    tests_run++;
    if (bad !== 0) begin tests_failed++; $display("[TB] FAIL after abort: got %0d bad cycles, expected 0", bad); end
    launch(28'd2000, 28'd2600, 28'd100, 16'd3, 12'h2AA);
    step();
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (fword !== '0 || pword !== '0 || fword_vld !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL async reset: got fword=%0d pword=%h vld=%b busy=%b done=%b, expected all 0",
               fword, pword, fword_vld, busy, done);
    end
    #1;
    rst = 1'b0;
    launch(28'd3000, 28'd3100, 28'd50, 16'd2, 12'h077);
    tests_run++;
    if (busy !== 1'b1 || fword_vld !== 1'b1 || fword !== 28'd3000 || pword !== 12'h077) begin
      tests_failed++;
      $display("[TB] FAIL start after reset: got busy=%b vld=%b fword=%0d pword=%h, expected 1 1 3000 077",
               busy, fword_vld, fword, pword);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
  endtask

`ifdef SWEEP_LOOP_EN
  task automatic test_loop();
    logic [FW_W-1:0] ef [7] = '{28'd1000, 28'd1100, 28'd1200, 28'd1000, 28'd1100, 28'd1200, 28'd1000};
    launch(28'd1000, 28'd1200, 28'd100, 16'd1, 12'h0AB);
    for (int i = 0; i < 7; i++) begin
      tests_run++;
      if (fword_vld !== 1'b1 || fword !== ef[i] || done !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL loop cycle %0d: got vld=%b fword=%0d done=%b, expected 1 %0d 0", i + 1, fword_vld, fword, done, ef[i]);
      end
      step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL loop abort: got busy=%b done=%b, expected 0 0", busy, done);
    end
    step();
  endtask
`endif

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    test_reset();
`ifdef SWEEP_LOOP_EN
    test_loop();
`else
    test_basic_up();
    test_clamp();
    test_down();
    test_no_wrap();
    test_single_point();
    test_ignored_start();
`endif
    test_abort_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
